// File: rtl/clk_div_pkg.sv
// Shared types and constants for the clock-enable divider controller.
package clk_div_pkg;

  localparam int CLK_DIV_CNT_W = 16;
  localparam int MIN_DIV       = 2;

  typedef enum logic [1:0] {
    ST_STOP = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } state_e;

endpackage

// File: rtl/clk_div_core.sv
// Period counter with boundary detect and registered tick / square-wave outputs.
module clk_div_core
  import clk_div_pkg::*;
#(
  parameter int CNT_W = CLK_DIV_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] div_i,
  input  logic             run_i,
  input  logic             load_i,
  output logic             boundary_o,
  output logic             tick_o,
  output logic             div_out_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, div_out_q;

  assign boundary_o = run_i && (cnt_q == (div_i - CNT_W'(1)));

  // Wrapping at the boundary (or restarting on load) keeps cnt below div_i.
  always_comb begin
    cnt_d = '0;
    if (run_i && !load_i && !boundary_o) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      tick_q    <= 1'b0;
      div_out_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      tick_q    <= boundary_o;
      div_out_q <= run_i && (cnt_d >= (div_i >> 1));
    end
  end

  assign tick_o    = tick_q;
  assign div_out_o = div_out_q;

endmodule

// File: rtl/clk_div_ctrl.sv
// Divider controller: config handshake, pending update, clamp and RUN/PEND/STOP sequencing.
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int CNT_W       = CLK_DIV_CNT_W,
  parameter int DEFAULT_DIV = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_div,
  input  logic             cfg_en,
  output logic             tick,
  output logic             div_out,
  output logic [CNT_W-1:0] active_div,
  output logic             running,
  output logic             cfg_err,
  output state_e           dbg_state
);

  // Handshake: a transfer happens on a rising edge where cfg_valid and cfg_ready
  // are both high; cfg_ready is registered and drops for the whole PEND window.
  state_e           state_q, state_d;
  logic [CNT_W-1:0] active_div_q, active_div_d;
  logic [CNT_W-1:0] pend_div_q, pend_div_d;
  logic             pend_en_q, pend_en_d;
  logic             cfg_err_q, cfg_err_d;
  logic             cfg_ready_q, running_q;
  logic             xfer, load, boundary;
  logic [CNT_W-1:0] div_clamped;

  assign xfer        = cfg_valid && cfg_ready_q;
  assign div_clamped = (cfg_div < CNT_W'(MIN_DIV)) ? CNT_W'(MIN_DIV) : cfg_div;

  always_comb begin
    state_d      = state_q;
    active_div_d = active_div_q;
    pend_div_d   = pend_div_q;
    pend_en_d    = pend_en_q;
    cfg_err_d    = cfg_err_q || (xfer && (cfg_div < CNT_W'(MIN_DIV)));
    load         = 1'b0;
    case (state_q)
      ST_STOP: begin
        if (xfer) begin
          active_div_d = div_clamped;
          load         = 1'b1;
          state_d      = cfg_en ? ST_RUN : ST_STOP;
        end
      end
      ST_RUN: begin
        if (xfer) begin
          pend_div_d = div_clamped;
          pend_en_d  = cfg_en;
          state_d    = ST_PEND;
        end
      end
      ST_PEND: begin
        // Updates land only on the boundary so the old period always completes.
        if (boundary) begin
          if (pend_en_q) begin
            active_div_d = pend_div_q;
            load         = 1'b1;
            state_d      = ST_RUN;
          end else begin
            state_d = ST_STOP;
          end
        end
      end
      default: state_d = ST_STOP;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_RUN;
      active_div_q <= CNT_W'(DEFAULT_DIV);
      pend_div_q   <= '0;
      pend_en_q    <= 1'b0;
      cfg_err_q    <= 1'b0;
      cfg_ready_q  <= 1'b1;
      running_q    <= 1'b1;
    end else begin
      state_q      <= state_d;
      active_div_q <= active_div_d;
      pend_div_q   <= pend_div_d;
      pend_en_q    <= pend_en_d;
      cfg_err_q    <= cfg_err_d;
      cfg_ready_q  <= (state_d != ST_PEND);
      running_q    <= (state_d != ST_STOP);
    end
  end

  clk_div_core #(.CNT_W(CNT_W)) u_core (
    .clk        (clk),
    .rst_n      (rst_n),
    .div_i      (active_div_q),
    .run_i      (state_q != ST_STOP),
    .load_i     (load),
    .boundary_o (boundary),
    .tick_o     (tick),
    .div_out_o  (div_out)
  );

  assign cfg_ready  = cfg_ready_q;
  assign active_div = active_div_q;
  assign running    = running_q;
  assign cfg_err    = cfg_err_q;
  assign dbg_state  = state_q;

endmodule
